// File: rtl/memory_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_memory_pkg
// Purpose  : Shared opcodes, FSM state type and helpers for the MIPS
//            memory-stage data-bus controller.
// Revision : 1.0 - initial release
// ============================================================================
package mips_memory_pkg;

  // MIPS primary opcodes for loads and stores
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } memory_state_t;

  // Word ops need a 4-byte aligned address, halfword ops a 2-byte aligned one.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_unit_if
// Purpose  : Avalon-style data bus between the memory stage and the data
//            memory slave (address, read/write, waitrequest, data, enables).
// Revision : 1.0 - initial release
// ============================================================================
interface memory_access_unit_if;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic        data_waitrequest;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;

  modport master (
    output data_address, data_read, data_write, data_writedata, data_byteenable,
    input  data_waitrequest, data_readdata
  );

  modport slave (
    input  data_address, data_read, data_write, data_writedata, data_byteenable,
    output data_waitrequest, data_readdata
  );
endinterface
`default_nettype wire

// File: rtl/memory_access_unit_lane_decoder.sv
`default_nettype none
// ============================================================================
// Module   : memory_lane_decoder
// Purpose  : Combinational byte-enable and store-lane replication for the
//            current load/store opcode and low address bits.
// Revision : 1.0 - initial release
// ============================================================================
module memory_lane_decoder
  import mips_memory_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rt,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata
);

  // Byte enables: sub-word ops select the addressed lanes, LWL/LWR select the
  // partial-word lanes, everything else is a full word.
  always_comb begin
    o_byteenable = 4'b1111;
    case (i_op)
      OP_LB, OP_LBU, OP_SB: o_byteenable = 4'b0001 << i_addr;
      OP_LH, OP_LHU, OP_SH: o_byteenable = i_addr[1] ? 4'b1100 : 4'b0011;
      OP_LWL: begin
        case (i_addr)
          2'd0:    o_byteenable = 4'b0001;
          2'd1:    o_byteenable = 4'b0011;
          2'd2:    o_byteenable = 4'b0111;
          default: o_byteenable = 4'b1111;
        endcase
      end
      OP_LWR: begin
        case (i_addr)
          2'd0:    o_byteenable = 4'b1111;
          2'd1:    o_byteenable = 4'b1110;
          2'd2:    o_byteenable = 4'b1100;
          default: o_byteenable = 4'b1000;
        endcase
      end
      default: o_byteenable = 4'b1111;
    endcase
  end

  // Store data is replicated across all lanes so the enables pick the right one.
  always_comb begin
    o_writedata = i_rt;
    case (i_op)
      OP_SB:   o_writedata = {4{i_rt[7:0]}};
      OP_SH:   o_writedata = {2{i_rt[15:0]}};
      default: o_writedata = i_rt;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_unit
// Purpose  : Memory-stage data-bus controller. Runs one Avalon-style
//            transaction per load/store, stalls the pipeline until done and
//            hands the raw read word plus byte enables to MEM/WB.
// Options  : MEMORY_ALIGN_CHECK_EN - adds address_error_memory and suppresses
//            bus transactions for misaligned word/halfword accesses.
// Revision : 1.0 - initial release
// ============================================================================
module memory_access_unit
  import mips_memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read_memory,
  input  logic        memory_write_memory,
  input  logic [5:0]  op_memory,
  input  logic [31:0] ALU_output_memory,
  input  logic [31:0] write_data_memory,
  output logic [31:0] read_data_memory,
  output logic [3:0]  byteenable_memory,
  output logic        memory_stall,
`ifdef MEMORY_ALIGN_CHECK_EN
  output logic        address_error_memory,
`endif
  memory_access_unit_if.master bus
);

  memory_state_t r_state;
  logic [31:0]   r_address;
  logic [31:0]   r_writedata;
  logic [3:0]    r_byteenable;
  logic          r_read;
  logic          r_write;
  logic [31:0]   r_read_data;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_addr_err;
  logic          w_req;

  memory_lane_decoder u_lane_decoder (
    .i_op         (op_memory),
    .i_addr       (ALU_output_memory[1:0]),
    .i_rt         (write_data_memory),
    .o_byteenable (w_be),
    .o_writedata  (w_wdata)
  );

`ifdef MEMORY_ALIGN_CHECK_EN
  assign w_addr_err           = misaligned(op_memory, ALU_output_memory[1:0]);
  assign address_error_memory = w_addr_err;
`else
  assign w_addr_err = 1'b0;
`endif

  // A misaligned access (when checked) never starts a bus cycle.
  assign w_req = (memory_read_memory | memory_write_memory) & ~w_addr_err;

  assign byteenable_memory    = w_be;
  assign read_data_memory     = r_read_data;
  assign bus.data_address     = r_address;
  assign bus.data_read        = r_read;
  assign bus.data_write       = r_write;
  assign bus.data_writedata   = r_writedata;
  assign bus.data_byteenable  = r_byteenable;

  // Stall while a request waits to launch and while the bus is busy; DONE lets
  // the pipeline advance.
  assign memory_stall = ((r_state == IDLE) & w_req) | (r_state == BUS);

  // Transaction FSM with registered bus outputs; write wins when both set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_address    <= 32'd0;
      r_writedata  <= 32'd0;
      r_byteenable <= 4'd0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_read_data  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_address    <= {ALU_output_memory[31:2], 2'b00};
            r_byteenable <= w_be;
            r_writedata  <= w_wdata;
            r_write      <= memory_write_memory;
            r_read       <= ~memory_write_memory;
            r_state      <= BUS;
          end
        end
        BUS: begin
          if (!bus.data_waitrequest) begin
            if (r_read) r_read_data <= bus.data_readdata;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_byteenable <= 4'd0;
            r_state      <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_unit
// Purpose  : Directed self-checking bench for memory_access_unit.
// Options  : MEMORY_ALIGN_CHECK_EN - also exercises the alignment check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_read_memory;
  logic        memory_write_memory;
  logic [5:0]  op_memory;
  logic [31:0] ALU_output_memory;
  logic [31:0] write_data_memory;
  logic [31:0] read_data_memory;
  logic [3:0]  byteenable_memory;
  logic        memory_stall;
`ifdef MEMORY_ALIGN_CHECK_EN
  logic        address_error_memory;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  memory_access_unit_if bus ();

  memory_access_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .memory_read_memory  (memory_read_memory),
    .memory_write_memory (memory_write_memory),
    .op_memory           (op_memory),
    .ALU_output_memory   (ALU_output_memory),
    .write_data_memory   (write_data_memory),
    .read_data_memory    (read_data_memory),
    .byteenable_memory   (byteenable_memory),
    .memory_stall        (memory_stall),
`ifdef MEMORY_ALIGN_CHECK_EN
    .address_error_memory(address_error_memory),
`endif
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    memory_read_memory  = 1'b0;
    memory_write_memory = 1'b0;
    op_memory           = 6'h00;
    ALU_output_memory   = 32'd0;
    write_data_memory   = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.data_waitrequest = 1'b0;
    bus.data_readdata    = 32'd0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (bus.data_address !== 32'd0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus.data_address); end
    n_cmp++; if (bus.data_writedata !== 32'd0) begin n_bad++; $display("FAIL rst_wdata got %h want 0", bus.data_writedata); end
    n_cmp++; if (bus.data_byteenable !== 4'd0) begin n_bad++; $display("FAIL rst_be got %b want 0000", bus.data_byteenable); end
    n_cmp++; if ({bus.data_read, bus.data_write, memory_stall} !== 3'b000) begin n_bad++; $display("FAIL rst_ctl got %b want 000", {bus.data_read, bus.data_write, memory_stall}); end
    n_cmp++; if (read_data_memory !== 32'd0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", read_data_memory); end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (memory_stall !== 1'b0) begin n_bad++; $display("FAIL nomem_stall got %b want 0", memory_stall); end
  endtask

  task automatic test_lw();
    int stalls;
    @(negedge clk);
    op_memory = 6'h23; ALU_output_memory = 32'h100; memory_read_memory = 1'b1;
    bus.data_waitrequest = 1'b0; bus.data_readdata = 32'hDEADBEEF;
    #1; stalls = int'(memory_stall);
    n_cmp++; if (byteenable_memory !== 4'b1111) begin n_bad++; $display("FAIL lw_bemem got %b want 1111", byteenable_memory); end
    n_cmp++; if (bus.data_read !== 1'b0) begin n_bad++; $display("FAIL lw_idle_read got %b want 0", bus.data_read); end
    @(negedge clk); #1; stalls += int'(memory_stall);
    n_cmp++; if (bus.data_read !== 1'b1) begin n_bad++; $display("FAIL lw_read got %b want 1", bus.data_read); end
    n_cmp++; if (bus.data_address !== 32'h100) begin n_bad++; $display("FAIL lw_addr got %h want 00000100", bus.data_address); end
    n_cmp++; if (bus.data_byteenable !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b want 1111", bus.data_byteenable); end
    @(negedge clk); #1; stalls += int'(memory_stall);
    n_cmp++; if (bus.data_read !== 1'b0) begin n_bad++; $display("FAIL lw_done_read got %b want 0", bus.data_read); end
    n_cmp++; if (read_data_memory !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata got %h want deadbeef", read_data_memory); end
    n_cmp++; if (stalls !== 2) begin n_bad++; $display("FAIL lw_stalls got %0d want 2", stalls); end
    idle_inputs();
  endtask

  task automatic test_sb();
    int stalls, writes;
    @(negedge clk);
    op_memory = 6'h28; ALU_output_memory = 32'h203; write_data_memory = 32'h000000A5;
    memory_write_memory = 1'b1;
    #1; stalls = int'(memory_stall); writes = int'(bus.data_write);
    @(negedge clk); #1; stalls += int'(memory_stall); writes += int'(bus.data_write);
    n_cmp++; if (bus.data_address !== 32'h200) begin n_bad++; $display("FAIL sb_addr got %h want 00000200", bus.data_address); end
    n_cmp++; if (bus.data_byteenable !== 4'b1000) begin n_bad++; $display("FAIL sb_be got %b want 1000", bus.data_byteenable); end
    n_cmp++; if (bus.data_writedata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_wdata got %h want a5a5a5a5", bus.data_writedata); end
    n_cmp++; if (bus.data_read !== 1'b0) begin n_bad++; $display("FAIL sb_read got %b want 0", bus.data_read); end
    @(negedge clk); #1; stalls += int'(memory_stall); writes += int'(bus.data_write);
    n_cmp++; if (writes !== 1) begin n_bad++; $display("FAIL sb_write_cycles got %0d want 1", writes); end
    n_cmp++; if (stalls !== 2) begin n_bad++; $display("FAIL sb_stalls got %0d want 2", stalls); end
    n_cmp++; if (read_data_memory !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sb_rdata_hold got %h want deadbeef", read_data_memory); end
    idle_inputs();
  endtask

  task automatic test_sh_wait();
    int stalls;
    @(negedge clk);
    op_memory = 6'h29; ALU_output_memory = 32'h42; write_data_memory = 32'h1234BEEF;
    memory_write_memory = 1'b1; bus.data_waitrequest = 1'b1;
    #1; stalls = int'(memory_stall);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1; stalls += int'(memory_stall);
      n_cmp++; if ({bus.data_write, bus.data_address, bus.data_byteenable, bus.data_writedata} !== {1'b1, 32'h40, 4'b1100, 32'hBEEFBEEF}) begin
        n_bad++; $display("FAIL sh_req_c%0d got w=%b a=%h be=%b d=%h want w=1 a=00000040 be=1100 d=beefbeef",
                          i, bus.data_write, bus.data_address, bus.data_byteenable, bus.data_writedata);
      end
      if (i == 3) bus.data_waitrequest = 1'b0;
    end
    @(negedge clk); #1; stalls += int'(memory_stall);
    n_cmp++; if (bus.data_write !== 1'b0) begin n_bad++; $display("FAIL sh_done_write got %b want 0", bus.data_write); end
    n_cmp++; if (stalls !== 5) begin n_bad++; $display("FAIL sh_stalls got %0d want 5", stalls); end
    idle_inputs();
  endtask

  task automatic test_lwl_lwr();
    @(negedge clk);
    op_memory = 6'h22; ALU_output_memory = 32'h11; #1;
    n_cmp++; if (byteenable_memory !== 4'b0011) begin n_bad++; $display("FAIL lwl_bemem got %b want 0011", byteenable_memory); end
    op_memory = 6'h26; #1;
    n_cmp++; if (byteenable_memory !== 4'b1110) begin n_bad++; $display("FAIL lwr_bemem got %b want 1110", byteenable_memory); end
    op_memory = 6'h22; memory_read_memory = 1'b1; bus.data_readdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    n_cmp++; if ({bus.data_read, bus.data_address, bus.data_byteenable} !== {1'b1, 32'h10, 4'b0011}) begin
      n_bad++; $display("FAIL lwl_bus got r=%b a=%h be=%b want r=1 a=00000010 be=0011", bus.data_read, bus.data_address, bus.data_byteenable);
    end
    @(negedge clk); #1;
    n_cmp++; if (read_data_memory !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lwl_rdata got %h want cafef00d", read_data_memory); end
    idle_inputs();
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    op_memory = 6'h2B; ALU_output_memory = 32'h300; write_data_memory = 32'h01020304;
    memory_read_memory = 1'b1; memory_write_memory = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({bus.data_read, bus.data_write, bus.data_writedata} !== {1'b0, 1'b1, 32'h01020304}) begin
      n_bad++; $display("FAIL rw_dir got r=%b w=%b d=%h want r=0 w=1 d=01020304", bus.data_read, bus.data_write, bus.data_writedata);
    end
    @(negedge clk); #1;
    n_cmp++; if (read_data_memory !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rw_rdata_hold got %h want cafef00d", read_data_memory); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op_memory = 6'h23; ALU_output_memory = 32'h104; memory_read_memory = 1'b1;
    bus.data_readdata = 32'h11111111;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if ({memory_stall, read_data_memory} !== {1'b0, 32'h11111111}) begin
      n_bad++; $display("FAIL b2b_first got s=%b d=%h want s=0 d=11111111", memory_stall, read_data_memory);
    end
    ALU_output_memory = 32'h108; bus.data_readdata = 32'h22222222;
    @(negedge clk); #1;
    n_cmp++; if ({memory_stall, bus.data_read, read_data_memory} !== {1'b1, 1'b0, 32'h11111111}) begin
      n_bad++; $display("FAIL b2b_idle got s=%b r=%b d=%h want s=1 r=0 d=11111111", memory_stall, bus.data_read, read_data_memory);
    end
    @(negedge clk); #1;
    n_cmp++; if ({bus.data_read, bus.data_address} !== {1'b1, 32'h108}) begin
      n_bad++; $display("FAIL b2b_bus got r=%b a=%h want r=1 a=00000108", bus.data_read, bus.data_address);
    end
    @(negedge clk); #1;
    n_cmp++; if (read_data_memory !== 32'h22222222) begin n_bad++; $display("FAIL b2b_second got %h want 22222222", read_data_memory); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    op_memory = 6'h23; ALU_output_memory = 32'h500; memory_read_memory = 1'b1;
    bus.data_waitrequest = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.data_read !== 1'b1) begin n_bad++; $display("FAIL rmb_pre_read got %b want 1", bus.data_read); end
    reset = 1'b1; #1;
    n_cmp++; if ({bus.data_read, bus.data_address} !== {1'b0, 32'h0}) begin
      n_bad++; $display("FAIL rmb_async got r=%b a=%h want r=0 a=00000000", bus.data_read, bus.data_address);
    end
    idle_inputs();
    bus.data_waitrequest = 1'b0;
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if ({memory_stall, bus.data_read} !== 2'b00) begin n_bad++; $display("FAIL rmb_add0 got s/r=%b want 00", {memory_stall, bus.data_read}); end
    @(negedge clk); #1;
    n_cmp++; if ({memory_stall, bus.data_read} !== 2'b00) begin n_bad++; $display("FAIL rmb_add1 got s/r=%b want 00", {memory_stall, bus.data_read}); end
  endtask

`ifdef MEMORY_ALIGN_CHECK_EN
  task automatic test_align();
    @(negedge clk);
    op_memory = 6'h23; ALU_output_memory = 32'h102; memory_read_memory = 1'b1;
    bus.data_readdata = 32'h0BADF00D; #1;
    n_cmp++; if ({address_error_memory, memory_stall} !== 2'b10) begin
      n_bad++; $display("FAIL al_lw got err/stall=%b want 10", {address_error_memory, memory_stall});
    end
    @(negedge clk); #1;
    n_cmp++; if ({bus.data_read, memory_stall, read_data_memory} !== {1'b0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL al_nobus got r=%b s=%b d=%h want r=0 s=0 d=00000000", bus.data_read, memory_stall, read_data_memory);
    end
    memory_read_memory = 1'b0; op_memory = 6'h21; ALU_output_memory = 32'h42; #1;
    n_cmp++; if (address_error_memory !== 1'b0) begin n_bad++; $display("FAIL al_lh_ok got %b want 0", address_error_memory); end
    op_memory = 6'h29; ALU_output_memory = 32'h41; #1;
    n_cmp++; if (address_error_memory !== 1'b1) begin n_bad++; $display("FAIL al_sh_bad got %b want 1", address_error_memory); end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_sh_wait();
    test_lwl_lwr();
    test_rw_both();
    test_back_to_back();
    test_reset_mid_bus();
`ifdef MEMORY_ALIGN_CHECK_EN
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage data-bus controller of the pipelined MIPS core. Takes the load/store request in the memory stage, generates the word address, byte enables and lane-aligned store data, runs one Avalon-style transaction with `waitrequest` handshake, and stalls the pipeline until the access completes. It feeds the memory/writeback pipeline register with the raw read word and the byte-enable pattern the writeback stage uses for load merging.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock. One clock domain; all state on rising edge.
- `reset`  in  1  asynchronous, active-high. Clears all state immediately.
- `memory_read_memory`  in  1  load in memory stage.
- `memory_write_memory`  in  1  store in memory stage.
- `op_memory`  in  6  MIPS primary opcode.
- `ALU_output_memory`  in  32  effective byte address.
- `write_data_memory`  in  32  rt value for stores.
- `data_address`  out  32  word-aligned bus address, `{addr[31:2],2'b00}`.
- `data_read`  out  1  bus read request.
- `data_write`  out  1  bus write request.
- `data_waitrequest`  in  1  slave not ready; request must be held.
- `data_writedata`  out  32  lane-aligned store data.
- `data_byteenable`  out  4  bus byte enables; bit i selects bits 8i+7:8i.
- `data_readdata`  in  32  read word; valid in a cycle with `data_read`=1 and `data_waitrequest`=0.
- `read_data_memory`  out  32  captured read word, to MEM/WB.
- `byteenable_memory`  out  4  byte-enable pattern for current op, to MEM/WB.
- `memory_stall`  out  1  freezes all stages up to and including memory.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE, no request: `memory_stall`=0, bus idle. IDLE, request: latch address, byte enables, writedata and direction into bus registers; `memory_stall`=1; go to BUS.
- BUS: `data_read`/`data_write` held with stable address/data/enables. If `data_waitrequest`=0: capture `data_readdata` into `read_data_memory` (reads only), go to DONE. Else stay; `memory_stall`=1.
- DONE: bus outputs deasserted, `memory_stall`=0 (the pipeline advances at this edge); go to IDLE.
- Read and write both asserted: treated as a write.
- Byte enables (a = address[1:0]): LB/LBU/SB → `1<<a`; LH/LHU/SH → a[1] ? 1100 : 0011; LW/SW → 1111; LWL → a=0:0001, 1:0011, 2:0111, 3:1111; LWR → a=0:1111, 1:1110, 2:1100, 3:1000; any other op → 1111.
- Writedata: SB → `{4{rt[7:0]}}`; SH → `{2{rt[15:0]}}`; SW → rt.
- `byteenable_memory` is combinational from current `op_memory`/address at all times.
- `read_data_memory` holds its value until the next completed read.

## Timing
- Reset values: state IDLE; `data_address`, `data_writedata`, `read_data_memory` = 0; `data_byteenable`=0; `data_read`, `data_write`, `memory_stall` = 0.
- Zero-wait access: IDLE (stall) → BUS (handshake) → DONE (no stall). Three cycles in the memory stage. Each waitrequest cycle adds one.
- Non-memory instruction: zero added latency.
- Waitrequest held indefinitely: remains in BUS with stall high, no timeout.
- Reset during BUS: bus request drops asynchronously and the transaction is abandoned. After release the FSM is in IDLE.

## Configuration
- `MEMORY_ALIGN_CHECK_EN` defined: adds output `address_error_memory` (1 bit, reset 0, combinational). It is high for LW/SW with a≠0, and for LH/LHU/SH with a[0]=1. While high there is no bus transaction: FSM stays in IDLE, stall is 0, and `read_data_memory` is unchanged.
- Not defined: the port is absent. Misaligned accesses proceed using the byte-enable table above.

## Structure
- Package `mips_memory_pkg`: opcode localparams (LB 0x20, LH 0x21, LWL 0x22, LW 0x23, LBU 0x24, LHU 0x25, LWR 0x26, SB 0x28, SH 0x29, SW 0x2B) and the `memory_state_t` enum.
- Sub-module `memory_lane_decoder`: combinational op + address + rt → byteenable and writedata. Instantiated once.

## Test plan
- LW at 0x100, waitrequest low, readdata 0xDEADBEEF → `data_address`=0x100, BE=1111; stall high for 2 cycles; `read_data_memory`=0xDEADBEEF in DONE.
- SB at 0x203, rt=0x000000A5 → `data_address`=0x200, BE=1000, writedata=0xA5A5A5A5, `data_write` for 1 cycle.
- SH at 0x42, waitrequest high for 3 cycles → BE=1100, writedata upper half = rt[15:0], request stable throughout, total stall 5 cycles.
- LWL at 0x11 / LWR at 0x11 → BE 0011 / 1110; `byteenable_memory` matches.
- Reset asserted mid-BUS → `data_read` drops immediately; after release, an ADD passes with stall=0.
- With `MEMORY_ALIGN_CHECK_EN`: LW at 0x102 → `address_error_memory`=1, no `data_read`, stall 0.
